uart_cmd_parser: RTL

//  Sits downstream of the 16x-oversampled UART receiver; consumes its one-cycle

---
 rtl/uart_cmd_parser.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
`timescale 1ns/1ps
// ASCII line-command parser: turns "w addr data" / "r addr" lines from a UART
// receiver into local-bus cycles and streams hex read data or "?" back out.
module uart_cmd_parser #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int ACK_TO = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_byte,
  output logic              bus_wr,
  output logic              bus_rd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              tx_valid,
  output logic [7:0]        tx_byte,
  input  logic              tx_ready,
  output logic              err_strb
);
  localparam int NA   = ADDR_W / 4;
  localparam int ND   = DATA_W / 4;
  localparam int CW   = $clog2(ND + 2);
  localparam int TW   = $clog2(ACK_TO + 1);
  localparam int IW   = $clog2(ND + 1);
  localparam int DW_B = $clog2(DATA_W);

  localparam logic [7:0]    CH_CR    = 8'h0D;
  localparam logic [7:0]    CH_LF    = 8'h0A;
  localparam logic [7:0]    CH_SP    = 8'h20;
  localparam logic [7:0]    CH_Q     = 8'h3F;
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_NA   = CW'(NA);
  localparam logic [CW-1:0] CNT_ND   = CW'(ND);
  localparam logic [TW-1:0] TO_ZERO  = TW'(32'd0);
  localparam logic [TW-1:0] TO_ONE   = TW'(32'd1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TO) - TO_ONE;
  localparam logic [IW-1:0] IDX_ZERO = IW'(32'd0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);
  localparam logic [IW-1:0] LAST_IDX = IW'(ND);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SP1   = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_BUS   = 3'd4,
    S_RESP  = 3'd5,
    S_FLUSH = 3'd6
  } state_t;

  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) || ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // Letters A-F and a-f share the low nibble 1..6.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    logic [3:0] v;
    if (b <= 8'h39) v = b[3:0];
    else            v = b[3:0] + 4'd9;
    return v;
  endfunction

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = 8'h30 + {4'h0, n};
    else           c = 8'h37 + {4'h0, n};
    return c;
  endfunction

  // Byte idx of the reply: "?" LF on error, else ND hex digits MS first then LF.
  function automatic logic [7:0] resp_byte(input logic [IW-1:0] idx, input logic rerr,
                                           input logic [DATA_W-1:0] d);
    logic [7:0]      c;
    logic [IW-1:0]   rev;
    logic [DW_B-1:0] pos;
    rev = LAST_IDX - IDX_ONE - idx;
    pos = DW_B'({rev, 2'b00});
    if (rerr)                 c = (idx == IDX_ZERO) ? CH_Q : CH_LF;
    else if (idx < LAST_IDX)  c = hex_chr(d[pos +: 4]);
    else                      c = CH_LF;
    return c;
  endfunction

  state_t            state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     to_q, to_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              rerr_q, rerr_d;
  logic              txv_q, txv_d;
  logic [7:0]        txb_q, txb_d;
  logic              err_q, err_d;
  logic              bad_s, rx_hex_s, rx_eol_s, rx_sp_s;
  logic [3:0]        nib_s;
  logic [IW-1:0]     last_s;

  assign rx_hex_s = is_hex(rx_byte);
  assign rx_eol_s = (rx_byte == CH_CR) || (rx_byte == CH_LF);
  assign rx_sp_s  = (rx_byte == CH_SP);
  assign nib_s    = hex_val(rx_byte);
  assign last_s   = rerr_q ? IDX_ONE : LAST_IDX;

  // Next-state, accumulators, bus handshake and reply sequencing
  always_comb begin
    state_d = state_q;  op_wr_d = op_wr_q;  addr_d = addr_q;  data_d = data_q;
    cnt_d   = cnt_q;    to_d    = to_q;     wr_d   = wr_q;    rd_d   = rd_q;
    idx_d   = idx_q;    rerr_d  = rerr_q;   txv_d  = txv_q;   txb_d  = txb_q;
    err_d   = 1'b0;     bad_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_rdy) begin
          if ((rx_byte == 8'h77) || (rx_byte == 8'h57)) begin
            op_wr_d = 1'b1; state_d = S_SP1;
          end else if ((rx_byte == 8'h72) || (rx_byte == 8'h52)) begin
            op_wr_d = 1'b0; state_d = S_SP1;
          end else if (rx_eol_s) begin
            state_d = S_IDLE;
          end else begin
            bad_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SP1: begin
        if (rx_rdy && rx_sp_s) begin
          state_d = S_ADDR; addr_d = {ADDR_W{1'b0}}; cnt_d = CNT_ZERO;
        end else begin
          bad_s = rx_rdy;
        end
      end
      S_ADDR: begin
        if (!rx_rdy) begin
          state_d = S_ADDR;
        end else if (rx_hex_s && (cnt_q != CNT_NA)) begin
          addr_d = {addr_q[ADDR_W-5:0], nib_s}; cnt_d = cnt_q + CNT_ONE;
        end else if (rx_sp_s && op_wr_q && (cnt_q != CNT_ZERO)) begin
          state_d = S_DATA; data_d = {DATA_W{1'b0}}; cnt_d = CNT_ZERO;
        end else if (rx_eol_s && !op_wr_q && (cnt_q != CNT_ZERO)) begin
          state_d = S_BUS; rd_d = 1'b1; to_d = TO_ZERO;
        end else begin
          bad_s = 1'b1;
        end
      end
      S_DATA: begin
        if (!rx_rdy) begin
          state_d = S_DATA;
        end else if (rx_hex_s && (cnt_q != CNT_ND)) begin
          data_d = {data_q[DATA_W-5:0], nib_s}; cnt_d = cnt_q + CNT_ONE;
        end else if (rx_eol_s && (cnt_q != CNT_ZERO)) begin
          state_d = S_BUS; wr_d = 1'b1; to_d = TO_ZERO;
        end else begin
          bad_s = 1'b1;
        end
      end
      S_BUS: begin
        err_d = rx_rdy;
        if (bus_ack) begin
          wr_d = 1'b0; rd_d = 1'b0;
          if (rd_q) begin
            data_d = bus_rdata; state_d = S_RESP; idx_d = IDX_ZERO; rerr_d = 1'b0;
            txv_d = 1'b1; txb_d = hex_chr(bus_rdata[DATA_W-1 -: 4]);
          end else begin
            state_d = S_IDLE;
          end
        end else if (to_q == TO_LAST) begin
          wr_d = 1'b0; rd_d = 1'b0; err_d = 1'b1;
          state_d = S_RESP; idx_d = IDX_ZERO; rerr_d = 1'b1; txv_d = 1'b1; txb_d = CH_Q;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      S_RESP: begin
        err_d = rx_rdy;
        if (txv_q && tx_ready) begin
          if (idx_q == last_s) begin
            txv_d = 1'b0; state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_ONE;
            txb_d = resp_byte(idx_q + IDX_ONE, rerr_q, data_q);
          end
        end else begin
          state_d = S_RESP;
        end
      end
      S_FLUSH: begin
        if (rx_rdy && rx_eol_s) begin
          state_d = S_RESP; idx_d = IDX_ZERO; rerr_d = 1'b1; txv_d = 1'b1; txb_d = CH_Q;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: begin
        state_d = S_IDLE; wr_d = 1'b0; rd_d = 1'b0; txv_d = 1'b0;
      end
    endcase
    // An offending EOL already ends the line, so skip FLUSH and reply at once.
    if (bad_s) begin
      err_d = 1'b1;
      if (rx_eol_s) begin
        state_d = S_RESP; idx_d = IDX_ZERO; rerr_d = 1'b1; txv_d = 1'b1; txb_d = CH_Q;
      end else begin
        state_d = S_FLUSH;
      end
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;  op_wr_q <= 1'b0;  addr_q <= {ADDR_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};  cnt_q <= CNT_ZERO;  to_q <= TO_ZERO;
      wr_q    <= 1'b0;  rd_q <= 1'b0;  idx_q <= IDX_ZERO;  rerr_q <= 1'b0;
      txv_q   <= 1'b0;  txb_q <= 8'h00;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  op_wr_q <= op_wr_d;  addr_q <= addr_d;
      data_q  <= data_d;   cnt_q   <= cnt_d;    to_q   <= to_d;
      wr_q    <= wr_d;     rd_q    <= rd_d;     idx_q  <= idx_d;  rerr_q <= rerr_d;
      txv_q   <= txv_d;    txb_q   <= txb_d;    err_q  <= err_d;
    end
  end

  assign bus_wr    = wr_q;
  assign bus_rd    = rd_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = data_q;
  assign tx_valid  = txv_q;
  assign tx_byte   = txb_q;
  assign err_strb  = err_q;
endmodule
